// File: rtl/fpu_share_arbiter.sv
// Round-robin front end that shares one FPU between NumReq requesters, tagging
// each issued op with its requester index and routing results back by tag.
// Op-field widths follow the fpnew_pkg encodings (roundmode 3, operation 4,
// fp_format 3, int_format 2, status 5 bits).
`timescale 1ns/1ps

// Protocol and state checks kept out of the datapath module.
module fpu_share_arbiter_chk #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdWidth        = $clog2(NumReq),
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input logic                              clk_i,
  input logic                              rst_i,
  input logic                              lock_i,
  input logic [IdWidth-1:0]                grant_i,
  input logic                              out_valid_i,
  input logic                              out_ready_i,
  input logic [IdWidth-1:0]                tag_i,
  input logic [NumReq-1:0][CntWidth-1:0]   cnt_i
);

  localparam logic [CntWidth-1:0] MAX_CNT = CntWidth'(MaxOutstanding);

  a_grant_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    lock_i |-> (grant_i == $past(grant_i)));

  a_tag_range: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_i |-> (32'(tag_i) < NumReq));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_i && out_ready_i && (32'(tag_i) < NumReq)) |-> (cnt_i[tag_i] != '0));

  for (genvar i = 0; i < int'(NumReq); i++) begin : g_cnt_chk
    a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
      cnt_i[i] <= MAX_CNT);
  end

endmodule

module fpu_share_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned Width          = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdWidth        = $clog2(NumReq),
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][2:0][Width-1:0]  req_operands_i,
  input  logic [NumReq-1:0][2:0]             req_rnd_mode_i,
  input  logic [NumReq-1:0][3:0]             req_op_i,
  input  logic [NumReq-1:0]                  req_op_mod_i,
  input  logic [NumReq-1:0][2:0]             req_src_fmt_i,
  input  logic [NumReq-1:0][2:0]             req_dst_fmt_i,
  input  logic [NumReq-1:0][1:0]             req_int_fmt_i,
  output logic                               fpu_in_valid_o,
  input  logic                               fpu_in_ready_i,
  output logic [2:0][Width-1:0]              fpu_operands_o,
  output logic [2:0]                         fpu_rnd_mode_o,
  output logic [3:0]                         fpu_op_o,
  output logic                               fpu_op_mod_o,
  output logic [2:0]                         fpu_src_fmt_o,
  output logic [2:0]                         fpu_dst_fmt_o,
  output logic [1:0]                         fpu_int_fmt_o,
  output logic [IdWidth-1:0]                 fpu_tag_o,
  output logic                               fpu_flush_o,
  input  logic [Width-1:0]                   fpu_result_i,
  input  logic [4:0]                         fpu_status_i,
  input  logic [IdWidth-1:0]                 fpu_tag_i,
  input  logic                               fpu_out_valid_i,
  output logic                               fpu_out_ready_o,
  input  logic                               fpu_busy_i,
  output logic [NumReq-1:0]                  resp_valid_o,
  input  logic [NumReq-1:0]                  resp_ready_i,
  output logic [Width-1:0]                   resp_result_o,
  output logic [4:0]                         resp_status_o,
  input  logic                               flush_i,
  output logic                               busy_o
);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_e;

  localparam logic [CntWidth-1:0] MAX_CNT = CntWidth'(MaxOutstanding);

  state_e                            state_r, state_nxt_s;
  logic [IdWidth-1:0]                ptr_r, lock_idx_r;
  logic [NumReq-1:0][CntWidth-1:0]   cnt_r, cnt_nxt_s;
  logic [NumReq-1:0]                 eligible_s;
  logic [IdWidth-1:0]                arb_grant_s, grant_s, cand_s;
  logic                              gate_s, issue_s, retire_s, tag_ok_s;
  logic                              inc_s, dec_s, cnt_busy_s;

  // Eligibility and round-robin pick; the reverse scan lets the lowest offset from ptr win.
  always_comb begin
    arb_grant_s = ptr_r;
    cand_s      = ptr_r;
    for (int i = 0; i < int'(NumReq); i++) begin
      eligible_s[i] = req_valid_i[i] & (cnt_r[i] != MAX_CNT);
    end
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      cand_s      = IdWidth'((int'(ptr_r) + k) % int'(NumReq));
      arb_grant_s = eligible_s[cand_s] ? cand_s : arb_grant_s;
    end
  end

  // Input mux, handshakes and response routing, all combinational.
  always_comb begin
    gate_s          = rst_i | flush_i;
    grant_s         = (state_r == ST_LOCK) ? lock_idx_r : arb_grant_s;
    fpu_in_valid_o  = ~gate_s & ((state_r == ST_LOCK) | (|eligible_s));
    issue_s         = fpu_in_valid_o & fpu_in_ready_i;
    req_ready_o     = issue_s ? (NumReq'(1) << grant_s) : '0;
    fpu_operands_o  = req_operands_i[grant_s];
    fpu_rnd_mode_o  = req_rnd_mode_i[grant_s];
    fpu_op_o        = req_op_i[grant_s];
    fpu_op_mod_o    = req_op_mod_i[grant_s];
    fpu_src_fmt_o   = req_src_fmt_i[grant_s];
    fpu_dst_fmt_o   = req_dst_fmt_i[grant_s];
    fpu_int_fmt_o   = req_int_fmt_i[grant_s];
    fpu_tag_o       = grant_s;
    fpu_flush_o     = flush_i | rst_i;
    tag_ok_s        = (32'(fpu_tag_i) < NumReq);
    resp_valid_o    = (~gate_s & fpu_out_valid_i & tag_ok_s) ? (NumReq'(1) << fpu_tag_i) : '0;
    fpu_out_ready_o = ~gate_s & tag_ok_s & resp_ready_i[fpu_tag_i];
    retire_s        = fpu_out_valid_i & fpu_out_ready_o;
    resp_result_o   = fpu_result_i;
    resp_status_o   = fpu_status_i;
  end

  // Credit counters: a retire against an empty counter saturates at zero.
  always_comb begin
    cnt_busy_s = 1'b0;
    inc_s      = 1'b0;
    dec_s      = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) begin
      inc_s        = issue_s & (grant_s == IdWidth'(i));
      dec_s        = retire_s & (fpu_tag_i == IdWidth'(i)) & (cnt_r[i] != '0);
      cnt_nxt_s[i] = cnt_r[i] + CntWidth'(inc_s) - CntWidth'(dec_s);
      cnt_busy_s   = cnt_busy_s | (cnt_r[i] != '0);
    end
    busy_o = ~rst_i & (fpu_busy_i | cnt_busy_s | (state_r == ST_LOCK));
  end

  // Grant FSM: an offered but unaccepted op freezes the grant until it is taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ARB: begin
        if (fpu_in_valid_o && !fpu_in_ready_i) begin
          state_nxt_s = ST_LOCK;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_LOCK: begin
        if (issue_s) begin
          state_nxt_s = ST_ARB;
        end else begin
          state_nxt_s = ST_LOCK;
        end
      end
      default: state_nxt_s = ST_ARB;
    endcase
  end

  // State registers; flush drops credits and the lock but keeps the RR pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_ARB;
      ptr_r      <= '0;
      lock_idx_r <= '0;
      cnt_r      <= '0;
    end else if (flush_i) begin
      state_r    <= ST_ARB;
      cnt_r      <= '0;
    end else begin
      state_r    <= state_nxt_s;
      lock_idx_r <= (state_r == ST_ARB) ? arb_grant_s : lock_idx_r;
      cnt_r      <= cnt_nxt_s;
      if (issue_s) begin
        ptr_r <= IdWidth'((int'(grant_s) + 1) % int'(NumReq));
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  fpu_share_arbiter_chk #(
    .NumReq         (NumReq),
    .MaxOutstanding (MaxOutstanding),
    .IdWidth        (IdWidth),
    .CntWidth       (CntWidth)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lock_i      (state_r == ST_LOCK),
    .grant_i     (grant_s),
    .out_valid_i (fpu_out_valid_i),
    .out_ready_i (fpu_out_ready_o),
    .tag_i       (fpu_tag_i),
    .cnt_i       (cnt_r)
  );

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Scoreboard bench for fpu_share_arbiter: stimulus queues expected issues and
// responses, negedge monitors pop and compare whenever a handshake occurs.
`timescale 1ns/1ps

module tb_fpu_share_arbiter;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [1:0]              req_valid, req_ready;
  logic [1:0][2:0][31:0]   req_operands;
  logic [1:0][2:0]         req_rnd, req_src, req_dst;
  logic [1:0][3:0]         req_op;
  logic [1:0]              req_op_mod;
  logic [1:0][1:0]         req_int;
  logic                    fpu_in_valid, fpu_in_ready;
  logic [2:0][31:0]        fpu_operands;
  logic [2:0]              fpu_rnd, fpu_src, fpu_dst;
  logic [3:0]              fpu_op;
  logic                    fpu_op_mod;
  logic [1:0]              fpu_int;
  logic [0:0]              fpu_tag_o, fpu_tag_i;
  logic                    fpu_flush;
  logic [31:0]             fpu_result, resp_result;
  logic [4:0]              fpu_status, resp_status;
  logic                    fpu_out_valid, fpu_out_ready, fpu_busy;
  logic [1:0]              resp_valid, resp_ready;
  logic                    flush, busy;

  int checks_total  = 0;
  int checks_passed = 0;
  int issue_q[$];
  logic [33:0] resp_q[$];

  always #5 clk = ~clk;

  fpu_share_arbiter #(.NumReq(2), .Width(32), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_operands_i(req_operands), .req_rnd_mode_i(req_rnd), .req_op_i(req_op),
    .req_op_mod_i(req_op_mod), .req_src_fmt_i(req_src), .req_dst_fmt_i(req_dst),
    .req_int_fmt_i(req_int),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_operands_o(fpu_operands), .fpu_rnd_mode_o(fpu_rnd), .fpu_op_o(fpu_op),
    .fpu_op_mod_o(fpu_op_mod), .fpu_src_fmt_o(fpu_src), .fpu_dst_fmt_o(fpu_dst),
    .fpu_int_fmt_o(fpu_int), .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_i),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_busy_i(fpu_busy),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result), .resp_status_o(resp_status),
    .flush_i(flush), .busy_o(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_opnd(input int t);
    return (t == 0) ? 32'h1111_0000 : 32'h2222_0001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_issue(input int t);
    issue_q.push_back(t);
  endtask

  task automatic drive_resp(input int t, input logic [31:0] r);
    fpu_out_valid = 1'b1;
    fpu_tag_i     = 1'(t);
    fpu_result    = r;
  endtask

  // Issue-side monitor.
  always @(negedge clk) begin
    int t;
    if (!rst && fpu_in_valid && fpu_in_ready) begin
      if (issue_q.size() == 0) begin
        check("issue_unexpected", 64'd1, 64'd0);
      end else begin
        t = issue_q.pop_front();
        check("issue_tag", 64'(fpu_tag_o), 64'(t));
        check("issue_req_ready", 64'(req_ready), 64'(2'b01 << t));
        check("issue_opnd0", 64'(fpu_operands[0]), 64'(exp_opnd(t)));
        check("issue_op", 64'(fpu_op), (t == 0) ? 64'd2 : 64'd5);
      end
    end
  end

  // Response-side monitor.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && |(resp_valid & resp_ready)) begin
      if (resp_q.size() == 0) begin
        check("resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = resp_q.pop_front();
        check("resp_valid", 64'(resp_valid), 64'(e[33:32]));
        check("resp_result", 64'(resp_result), 64'(e[31:0]));
        check("resp_out_ready", 64'(fpu_out_ready), 64'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    req_operands[0] = {32'h4000_0000, 32'h3F80_0000, 32'h1111_0000};
    req_operands[1] = {32'h4040_0000, 32'hBF80_0000, 32'h2222_0001};
    req_rnd = {3'd1, 3'd0}; req_op = {4'd5, 4'd2}; req_op_mod = 2'b00;
    req_src = {3'd0, 3'd0}; req_dst = {3'd0, 3'd0}; req_int = {2'd2, 2'd2};
    fpu_status = 5'b00001; fpu_result = 32'h0;
    // Reset with every input active: all outputs must stay gated.
    rst = 1'b1; flush = 1'b0; fpu_busy = 1'b1; req_valid = 2'b11; fpu_in_ready = 1'b1;
    fpu_out_valid = 1'b1; fpu_tag_i = 1'b0; resp_ready = 2'b11;
    tick();
    @(negedge clk);
    check("rst_in_valid", 64'(fpu_in_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_fpu_flush", 64'(fpu_flush), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_out_ready", 64'(fpu_out_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0; fpu_busy = 1'b0; req_valid = 2'b00; fpu_out_valid = 1'b0; resp_ready = 2'b00;
    tick();

    // Both requesting, FPU always ready: grants alternate.
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_issue(k % 2);
      tick();
    end
    req_valid = 2'b00;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      drive_resp(k / 2, 32'hC0DE_0000 + 32'(k));
      resp_q.push_back({2'b01 << (k / 2), 32'hC0DE_0000 + 32'(k)});
      tick();
    end
    fpu_out_valid = 1'b0;

    // Only requester 1 with ptr at 0, then both: ptr must have wrapped to 0.
    req_valid = 2'b10;
    exp_issue(1);
    @(negedge clk);
    check("single_req_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b11;
    exp_issue(0);
    tick();

    // Stall three cycles: grant frozen on requester 1.
    fpu_in_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_valid", 64'(fpu_in_valid), 64'd1);
      check("stall_tag", 64'(fpu_tag_o), 64'd1);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_opnd0", 64'(fpu_operands[0]), 64'(exp_opnd(1)));
      tick();
    end
    fpu_in_ready = 1'b1;
    exp_issue(1);
    tick();
    exp_issue(0);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("busy_credits", 64'(busy), 64'd1);
    tick();
    req_valid = 2'b10;
    exp_issue(1);
    tick();

    // Flush with credits {2,3} outstanding.
    flush = 1'b1; req_valid = 2'b11; drive_resp(0, 32'hDEAD_0000);
    @(negedge clk);
    check("flush_fpu_flush", 64'(fpu_flush), 64'd1);
    check("flush_in_valid", 64'(fpu_in_valid), 64'd0);
    check("flush_req_ready", 64'(req_ready), 64'd0);
    check("flush_resp_valid", 64'(resp_valid), 64'd0);
    tick();
    flush = 1'b0; req_valid = 2'b00; fpu_out_valid = 1'b0; resp_ready = 2'b00;
    @(negedge clk);
    check("post_flush_busy0", 64'(busy), 64'd0);
    fpu_busy = 1'b1;
    #1;
    check("post_flush_busy1", 64'(busy), 64'd1);
    fpu_busy = 1'b0;
    tick();

    // Credit limit on requester 0.
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      exp_issue(0);
      tick();
    end
    @(negedge clk);
    check("credit_block_valid", 64'(fpu_in_valid), 64'd0);
    check("credit_block_ready", 64'(req_ready), 64'd0);
    tick();
    req_valid = 2'b11;
    exp_issue(1);
    tick();
    req_valid = 2'b01; resp_ready = 2'b01; drive_resp(0, 32'hBEEF_0000);
    resp_q.push_back({2'b01, 32'hBEEF_0000});
    @(negedge clk);
    check("credit_same_cycle_block", 64'(fpu_in_valid), 64'd0);
    tick();
    fpu_out_valid = 1'b0;
    exp_issue(0);
    tick();
    req_valid = 2'b00;

    // Response for requester 1 held off by its ready.
    drive_resp(1, 32'h1234_5678); resp_ready = 2'b01;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("resp_hold_out_ready", 64'(fpu_out_ready), 64'd0);
      check("resp_hold_valid", 64'(resp_valid), 64'b10);
      tick();
    end
    resp_ready = 2'b11;
    resp_q.push_back({2'b10, 32'h1234_5678});
    tick();
    resp_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      drive_resp(0, 32'hAAAA_0000 + 32'(k));
      resp_q.push_back({2'b01, 32'hAAAA_0000 + 32'(k)});
      tick();
    end
    fpu_out_valid = 1'b0;
    @(negedge clk);
    check("drained_busy", 64'(busy), 64'd0);
    tick();
    tick();
    check("issue_q_empty", 64'(issue_q.size()), 64'd0);
    check("resp_q_empty", 64'(resp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Shares one fpnew_top instance between NumReq requesters, e.g. an integer core plus CV-X-IF coprocessor ports.
- Arbitrates incoming operations round-robin and tags each issued op with the requester index.
- Tracks outstanding ops per requester against a credit limit.
- Routes each FPU result back to its originating requester by tag.
- Sits directly between the requesters and the FPU input/output handshakes.

Parameters:
- NumReq, 2, number of requesters (≥2).
- Width, 32, FP operand/result width; must equal the FPU Features.Width.
- MaxOutstanding, 4, maximum in-flight ops per requester (≥1).
- IdWidth, $clog2(NumReq), derived; width of the FPU tag.
- CntWidth, $clog2(MaxOutstanding+1), derived; width of each credit counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NumReq  per-requester op valid.
- req_ready_o  out  NumReq  per-requester op accepted (valid & ready = handshake).
- req_operands_i  in  NumReq×3×Width  operands.
- req_rnd_mode_i, req_op_i, req_op_mod_i, req_src_fmt_i, req_dst_fmt_i, req_int_fmt_i  in  NumReq×(fpnew_pkg type)  op fields.
- fpu_in_valid_o  out  1  to FPU in_valid_i.
- fpu_in_ready_i  in  1  from FPU in_ready_o.
- fpu_operands_o, fpu_rnd_mode_o, fpu_op_o, fpu_op_mod_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o  out  matching  muxed fields of the granted requester.
- fpu_tag_o  out  IdWidth  granted requester index.
- fpu_flush_o  out  1  to FPU flush_i.
- fpu_result_i  in  Width  FPU result.
- fpu_status_i  in  fpnew_pkg::status_t  FPU status flags.
- fpu_tag_i  in  IdWidth  FPU tag_o.
- fpu_out_valid_i  in  1  FPU result valid.
- fpu_out_ready_o  out  1  result accepted.
- fpu_busy_i  in  1  FPU busy_o.
- resp_valid_o  out  NumReq  result valid, one-hot by tag.
- resp_ready_i  in  NumReq  requester accepts result.
- resp_result_o  out  Width  broadcast result.
- resp_status_o  out  status_t  broadcast status.
- flush_i  in  1  global flush.
- busy_o  out  1  any op in flight.

Behaviour:
- Reset (rst_i high at a clock edge): RR pointer=0, all credit counters=0, lock=0. Outputs while held in reset: fpu_in_valid_o=0, req_ready_o=0, fpu_flush_o=1, resp_valid_o=0, fpu_out_ready_o=0, busy_o=0.
- Eligibility: eligible[i] = req_valid_i[i] & (cnt[i] != MaxOutstanding).
- Grant state machine, two states:
  - ARB: grant = first eligible index at or after ptr, wrapping modulo NumReq. fpu_in_valid_o = |eligible.
  - LOCK: entered at a clock edge when fpu_in_valid_o=1 and fpu_in_ready_i=0. Grant index is frozen and fpu_in_valid_o stays 1. Exits to ARB on the next handshake.
  - Requesters must hold valid and data stable while not yet accepted.
- Issue handshake: fpu_in_valid_o & fpu_in_ready_i. On it: req_ready_o[grant]=1 in the same cycle (combinational), ptr <= (grant+1) mod NumReq, cnt[grant]++. All other req_ready_o bits are 0.
- Input path is zero-latency combinational: no registers on data.
- Response path: resp_valid_o[fpu_tag_i] = fpu_out_valid_i; fpu_out_ready_o = resp_ready_i[fpu_tag_i]. On that handshake, cnt[fpu_tag_i]--.
- Simultaneous issue and response for the same requester leave its counter unchanged.
- A response with cnt[tag]==0 is a protocol error: assertion fires; counter saturates at 0.
- The credit check uses the registered counter value, so issue is blocked at MaxOutstanding even if a response retires in the same cycle.
- flush_i:
  - fpu_flush_o = flush_i | rst_i.
  - While flush_i is high: fpu_in_valid_o=0, req_ready_o=0, resp_valid_o=0.
  - Next edge: all counters=0, lock=0, ptr unchanged.
- busy_o = fpu_busy_i | (any cnt != 0) | lock.
- Assertions:
  - Grant stable while locked.
  - fpu_tag_i < NumReq whenever fpu_out_valid_i.
  - No counter exceeds MaxOutstanding.

Test Plan:
- Reset, then req_valid=2'b11 with fpu_in_ready always 1 → grants alternate 0,1,0,1 on consecutive cycles; fpu_tag_o follows 0,1,0,1.
- Only req 1 valid, ptr=0 → grant=1 in one cycle, req_ready_o=2'b10, ptr becomes 0.
- fpu_in_ready=0 for 3 cycles with both requesting → grant frozen at the first index and operands stable; accepted on cycle 4, then grant moves to the other requester.
- MaxOutstanding=4, req0 issues 4 with no responses → req_ready_o[0]=0 and req1 still served. One response tagged 0 → req0 issues again next cycle.
- Response tag=1 with resp_ready_i=2'b01 → fpu_out_ready_o=0 and cnt[1] held. Raise resp_ready_i[1] → handshake completes and cnt[1] decrements.
- flush_i pulse with cnt={2,3} → fpu_flush_o=1 in the same cycle; next cycle counters=0, busy_o=fpu_busy_i.
